// File: rtl/dispatch_pkg.sv
// Shared micro-op types and dispatch sizing for the rename->dispatch boundary.
package dispatch_pkg;

  localparam int DISPATCH_WIDTH = 4;
  localparam int IQ_FREE_W      = 4;
  localparam int ROB_FREE_W     = 6;
  localparam int ALLOC_W        = $clog2(DISPATCH_WIDTH + 1);

  typedef enum logic {
    IQ_INT = 1'b0,
    IQ_MEM = 1'b1
  } iq_code_t;

  typedef struct packed {
    logic     valid;
    iq_code_t iq_code;
    logic [7:0] tag;
  } micro_op_t;

endpackage

// File: rtl/dispatch_if.sv
// Dispatch-stage bundle: incoming uop group and credits, outgoing per-IQ lanes and stall.
interface dispatch_if;
  import dispatch_pkg::*;

  micro_op_t               dp_uops  [DISPATCH_WIDTH];
  logic [IQ_FREE_W-1:0]    iq_int_free;
  logic [IQ_FREE_W-1:0]    iq_mem_free;
  logic [ROB_FREE_W-1:0]   rob_free;
  logic                    stall;
  micro_op_t               int_uops [DISPATCH_WIDTH];
  micro_op_t               mem_uops [DISPATCH_WIDTH];
  logic [ALLOC_W-1:0]      rob_alloc;

  modport master (
    output dp_uops, iq_int_free, iq_mem_free, rob_free,
    input  stall, int_uops, mem_uops, rob_alloc
  );

  modport slave (
    input  dp_uops, iq_int_free, iq_mem_free, rob_free,
    output stall, int_uops, mem_uops, rob_alloc
  );
endinterface

// File: rtl/dispatch_compact.sv
// Packs selected slots into lanes 0.. in age order; purely combinational.
// Unselected lanes are driven all-zero, so their valid is 0.
module dispatch_compact
  import dispatch_pkg::*;
(
  input  micro_op_t                 uops  [DISPATCH_WIDTH],
  input  logic [DISPATCH_WIDTH-1:0] sel,
  output micro_op_t                 lanes [DISPATCH_WIDTH]
);

  logic [ALLOC_W-1:0] rank [DISPATCH_WIDTH];
  logic [ALLOC_W-1:0] cnt;

  // rank[i] is the lane a selected slot i lands in: number of older selected slots
  always_comb begin
    cnt = '0;
    for (int i = 0; i < DISPATCH_WIDTH; i++) begin
      rank[i] = cnt;
      if (sel[i]) cnt = cnt + ALLOC_W'(1);
    end
  end

  always_comb begin
    for (int j = 0; j < DISPATCH_WIDTH; j++) begin
      lanes[j] = '0;
      for (int i = 0; i < DISPATCH_WIDTH; i++) begin
        if (sel[i] && rank[i] == ALLOC_W'(j)) lanes[j] = uops[i];
      end
    end
  end

endmodule

// File: rtl/dispatch.sv
// In-order, zero-latency dispatch of a uop group to INT/MEM issue queues under IQ and ROB credits;
// stall holds the group until every valid slot has gone. Optional DISPATCH_PERF_EN adds stall_cycles.
module dispatch
  import dispatch_pkg::*;
(
  input  logic      clock,
  input  logic      reset,
  input  logic      clear,
  dispatch_if.slave dp
`ifdef DISPATCH_PERF_EN
  ,
  output logic [31:0] stall_cycles
`endif
);

  logic [DISPATCH_WIDTH-1:0] done_mask;
  logic [DISPATCH_WIDTH-1:0] disp;
  logic [DISPATCH_WIDTH-1:0] int_sel;
  logic [DISPATCH_WIDTH-1:0] mem_sel;
  logic                      blocked;
  logic                      active;
  logic [IQ_FREE_W-1:0]      int_used;
  logic [IQ_FREE_W-1:0]      mem_used;
  logic [ROB_FREE_W-1:0]     rob_used;
  logic [ALLOC_W-1:0]        alloc;
  logic                      has_room;

  micro_op_t group     [DISPATCH_WIDTH];
  micro_op_t int_lanes [DISPATCH_WIDTH];
  micro_op_t mem_lanes [DISPATCH_WIDTH];

  assign group = dp.dp_uops;

  // Reset is folded in so outputs go quiet asynchronously, not just at the next edge
  always_comb begin
    disp     = '0;
    int_sel  = '0;
    mem_sel  = '0;
    blocked  = 1'b0;
    int_used = '0;
    mem_used = '0;
    rob_used = '0;
    alloc    = '0;
    has_room = 1'b0;
    active   = reset & ~clear;
    for (int i = 0; i < DISPATCH_WIDTH; i++) begin
      if (active && group[i].valid && !done_mask[i] && !blocked) begin
        if (group[i].iq_code == IQ_MEM) has_room = (mem_used < dp.iq_mem_free);
        else                            has_room = (int_used < dp.iq_int_free);
        if (has_room && rob_used < dp.rob_free) begin
          disp[i]  = 1'b1;
          rob_used = rob_used + ROB_FREE_W'(1);
          alloc    = alloc + ALLOC_W'(1);
          if (group[i].iq_code == IQ_MEM) begin
            mem_sel[i] = 1'b1;
            mem_used   = mem_used + IQ_FREE_W'(1);
          end else begin
            int_sel[i] = 1'b1;
            int_used   = int_used + IQ_FREE_W'(1);
          end
        end else begin
          // First starved slot fences every younger slot this cycle
          blocked = 1'b1;
        end
      end
    end
  end

  assign dp.stall     = blocked;
  assign dp.rob_alloc = alloc;

  dispatch_compact u_int_compact (
    .uops  (group),
    .sel   (int_sel),
    .lanes (int_lanes)
  );

  dispatch_compact u_mem_compact (
    .uops  (group),
    .sel   (mem_sel),
    .lanes (mem_lanes)
  );

  assign dp.int_uops = int_lanes;
  assign dp.mem_uops = mem_lanes;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      done_mask <= '0;
    end else if (clear || !dp.stall) begin
      done_mask <= '0;
    end else begin
      done_mask <= done_mask | disp;
    end
  end

`ifdef DISPATCH_PERF_EN
  // stall is already forced low under clear, so cleared cycles are not counted
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      stall_cycles <= '0;
    end else if (dp.stall) begin
      stall_cycles <= stall_cycles + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_dispatch.sv
// Self-checking bench for dispatch: directed scenarios plus randomized traffic against a queue-based model.
module tb_dispatch;
  import dispatch_pkg::*;

  logic clock = 1'b0;
  logic reset;
  logic clear;
`ifdef DISPATCH_PERF_EN
  logic [31:0] stall_cycles;
`endif

  dispatch_if bus ();

  dispatch dut (
    .clock (clock),
    .reset (reset),
    .clear (clear),
    .dp    (bus)
`ifdef DISPATCH_PERF_EN
    ,
    .stall_cycles (stall_cycles)
`endif
  );

  always #5 clock = ~clock;

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: walk the group oldest-first spending credits, queue what goes where
  logic [DISPATCH_WIDTH-1:0] m_done  = '0;
  logic [DISPATCH_WIDTH-1:0] e_disp;
  logic                      e_stall;
  logic                      m_stall = 1'b0;
  logic                      blk;
  int                        ri, rm, rr, room;
  micro_op_t                 u;
  micro_op_t                 int_q[$];
  micro_op_t                 mem_q[$];

  always @(negedge clock) begin
    if (!reset) m_done = '0;
    int_q.delete();
    mem_q.delete();
    e_disp  = '0;
    e_stall = 1'b0;
    if (reset && !clear) begin
      ri  = int'(bus.iq_int_free);
      rm  = int'(bus.iq_mem_free);
      rr  = int'(bus.rob_free);
      blk = 1'b0;
      for (int i = 0; i < DISPATCH_WIDTH; i++) begin
        u = bus.dp_uops[i];
        if (u.valid && !m_done[i]) begin
          room = (u.iq_code == IQ_MEM) ? rm : ri;
          if (!blk && rr > 0 && room > 0) begin
            e_disp[i] = 1'b1;
            rr--;
            if (u.iq_code == IQ_MEM) begin mem_q.push_back(u); rm--; end
            else                     begin int_q.push_back(u); ri--; end
          end else begin
            blk     = 1'b1;
            e_stall = 1'b1;
          end
        end
      end
    end
    chk("stall", bus.stall, e_stall);
    chk("rob_alloc", bus.rob_alloc, int_q.size() + mem_q.size());
    chk("done_mask", dut.done_mask, m_done);
    for (int j = 0; j < DISPATCH_WIDTH; j++) begin
      if (j < int_q.size()) chk("int_lane", bus.int_uops[j], int_q[j]);
      else                  chk("int_lane_idle", bus.int_uops[j].valid, 0);
      if (j < mem_q.size()) chk("mem_lane", bus.mem_uops[j], mem_q[j]);
      else                  chk("mem_lane_idle", bus.mem_uops[j].valid, 0);
    end
    m_stall = e_stall;
    if (!reset || clear || !e_stall) m_done = '0;
    else                             m_done = m_done | e_disp;
  end

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic set_group(input logic [3:0] vmask, input logic [3:0] mem_mask, input logic [7:0] tag_base);
    for (int i = 0; i < DISPATCH_WIDTH; i++) begin
      bus.dp_uops[i].valid   = vmask[i];
      bus.dp_uops[i].iq_code = mem_mask[i] ? IQ_MEM : IQ_INT;
      bus.dp_uops[i].tag     = tag_base + 8'(i);
    end
  endtask

  task automatic set_credits(input int fi, input int fm, input int fr);
    bus.iq_int_free = IQ_FREE_W'(fi);
    bus.iq_mem_free = IQ_FREE_W'(fm);
    bus.rob_free    = ROB_FREE_W'(fr);
  endtask

`ifdef DISPATCH_PERF_EN
  logic [31:0] perf_start;
`endif

  initial begin
    reset = 1'b0;
    clear = 1'b0;
    set_group(4'b0000, 4'b0000, 8'h00);
    set_credits(0, 0, 0);
    #2;
    chk("reset_stall", bus.stall, 0);
    chk("reset_alloc", bus.rob_alloc, 0);
    chk("reset_done_mask", dut.done_mask, 0);
    step();
    reset = 1'b1;

    // Four INT uops with exactly enough credit
    set_group(4'b1111, 4'b0000, 8'h10);
    set_credits(4, 0, 8);
    #1;
    chk("full_int_stall", bus.stall, 0);
    chk("full_int_alloc", bus.rob_alloc, 4);
    chk("full_int_valids", {bus.int_uops[3].valid, bus.int_uops[2].valid,
                            bus.int_uops[1].valid, bus.int_uops[0].valid}, 4'b1111);
    step();

    // INT,MEM,INT,MEM with one INT credit: two cycles
    set_group(4'b1111, 4'b1010, 8'h20);
    set_credits(1, 4, 8);
    #1;
    chk("split_c1_stall", bus.stall, 1);
    chk("split_c1_alloc", bus.rob_alloc, 2);
    chk("split_c1_int0", bus.int_uops[0].tag, 8'h20);
    chk("split_c1_mem0", bus.mem_uops[0].tag, 8'h21);
    step();
    chk("split_mask", dut.done_mask, 4'b0011);
    set_credits(2, 4, 8);
    #1;
    chk("split_c2_stall", bus.stall, 0);
    chk("split_c2_alloc", bus.rob_alloc, 2);
    chk("split_c2_int0", bus.int_uops[0].tag, 8'h22);
    chk("split_c2_mem0", bus.mem_uops[0].tag, 8'h23);
    step();

    // No ROB credit blocks the whole group
    set_group(4'b0111, 4'b0100, 8'h30);
    set_credits(4, 4, 0);
    for (int k = 0; k < 3; k++) begin
      #1;
      chk("rob0_stall", bus.stall, 1);
      chk("rob0_alloc", bus.rob_alloc, 0);
      chk("rob0_int0_vld", bus.int_uops[0].valid, 0);
      chk("rob0_mask", dut.done_mask, 0);
      step();
    end

    // Clear during a partial group
    set_group(4'b1111, 4'b0000, 8'h40);
    set_credits(1, 4, 8);
    step();
    chk("clr_pre_mask", dut.done_mask, 4'b0001);
    clear = 1'b1;
    #1;
    chk("clr_stall", bus.stall, 0);
    chk("clr_alloc", bus.rob_alloc, 0);
    chk("clr_int0_vld", bus.int_uops[0].valid, 0);
    step();
    clear = 1'b0;
    chk("clr_post_mask", dut.done_mask, 0);

    // Reset mid-stall discards progress
    set_group(4'b1111, 4'b0000, 8'h50);
    set_credits(1, 4, 8);
    step();
    chk("rst_pre_mask", dut.done_mask, 4'b0001);
    reset = 1'b0;
    #1;
    chk("rst_stall", bus.stall, 0);
    chk("rst_alloc", bus.rob_alloc, 0);
    chk("rst_int0_vld", bus.int_uops[0].valid, 0);
    chk("rst_mask", dut.done_mask, 0);
    step();
    reset = 1'b1;
    set_credits(4, 4, 8);
    #1;
    chk("rst_redo_alloc", bus.rob_alloc, 4);
    chk("rst_redo_int0", bus.int_uops[0].tag, 8'h50);
    chk("rst_redo_stall", bus.stall, 0);
    step();

`ifdef DISPATCH_PERF_EN
    set_group(4'b0011, 4'b0000, 8'h60);
    set_credits(4, 4, 0);
    perf_start = stall_cycles;
    for (int k = 0; k < 5; k++) begin
      clear = (k == 2);
      step();
    end
    clear = 1'b0;
    chk("perf_delta", stall_cycles - perf_start, 4);
    set_credits(4, 4, 8);
    step();
`endif

    // Randomized traffic; the group is held while the model says stall
    for (int n = 0; n < 800; n++) begin
      if (!m_stall) begin
        for (int i = 0; i < DISPATCH_WIDTH; i++) begin
          bus.dp_uops[i].valid   = ($urandom_range(0, 3) != 0);
          bus.dp_uops[i].iq_code = iq_code_t'($urandom_range(0, 1));
          bus.dp_uops[i].tag     = 8'($urandom);
        end
      end
      if ($urandom_range(0, 7) == 0) set_credits(15, 15, 63);
      else set_credits($urandom_range(0, 4), $urandom_range(0, 4), $urandom_range(0, 6));
      clear = ($urandom_range(0, 15) == 0);
      reset = ($urandom_range(0, 99) != 0);
      step();
    end
    reset = 1'b1;
    clear = 1'b0;
    step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
